nmr_acq_sequencer: RTL
======================

# nmr_acq_sequencer

Single-shot NMR experiment sequencer sitting between the host configuration registers, the `sin_source` DDS and the `dec_FIR` decimator output. On a start pulse it latches the experiment configuration, loads frequency and phase into `sin_source`, and gates an excitation pulse of programmed length. It then waits a programmed receiver dead time and captures a programmed number of decimated samples from `dec_FIR`, tagging the last one. Everything runs in the single `clk` domain.

## Interface
- `CW`, 24: width of the pulse, dead-time and sample counters.
- `DW`, 16: sample width; matches `dec_FIR` `m_axis_data_tdata`.
- `clk`  in  1  system clock, the same clock that drives `sin_source` and `dec_FIR` `aclk`.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin an experiment; ignored unless in IDLE.
- `abort`  in  1  terminates any experiment; takes priority over everything except `rst`.
- `cfg_frq`  in  32  DDS frequency word, latched at start.
- `cfg_phase`  in  32  DDS phase offset, latched at start.
- `cfg_pulse_len`  in  CW  excitation length in clk cycles; 0 means no pulse.
- `cfg_dead_len`  in  CW  dead time in clk cycles; 0 means no dead time.
- `cfg_n_samples`  in  CW  number of decimated samples to capture.
- `frq`  out  32  to `sin_source.frq`.
- `phase_offset`  out  32  to `sin_source.phase_offset`.
- `frq_valid`  out  1  one-cycle load strobe to `sin_source`.
- `tx_gate`  out  1  high during the excitation pulse.
- `s_tvalid`  in  1  from `dec_FIR` `m_axis_data_tvalid`.
- `s_tdata`  in  DW  from `dec_FIR` `m_axis_data_tdata`.
- `acq_valid`  out  1  captured sample strobe.
- `acq_data`  out  DW  captured sample.
- `acq_last`  out  1  marks the final captured sample, coincident with `acq_valid`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse when an abort terminates an active experiment.

## Operation
- States: IDLE, LOAD, PULSE, DEAD, ACQ, DONE.
- Register values after `rst`:
  - All outputs 0; `frq` and `phase_offset` are 0.
  - State is IDLE and all counters are 0.
- IDLE:
  - When `start` is high, latch `cfg_*` into shadow registers and go to LOAD.
  - `cfg_*` changes after start have no effect on the running experiment.
- LOAD (1 cycle):
  - `frq_valid`=1; `frq` and `phase_offset` drive the latched values.
  - `frq` and `phase_offset` hold those values until the next start or `rst`.
  - Next state: PULSE if pulse_len>0; else DEAD if dead_len>0; else ACQ if n_samples>0; else DONE.
- PULSE:
  - `tx_gate`=1 for exactly pulse_len cycles.
  - Then go to DEAD, ACQ or DONE, skipping zero-length stages as above.
- DEAD:
  - Exactly dead_len cycles. All `s_tvalid` samples are discarded.
- ACQ:
  - Each cycle with `s_tvalid`=1 registers `s_tdata` onto `acq_data` and pulses `acq_valid` on the next cycle.
  - Samples are counted from 0. The sample with index n_samples-1 also asserts `acq_last`, and the state moves to DONE.
  - `s_tvalid` in any other state produces no output.
- DONE (1 cycle): `done`=1, then IDLE.
- Abort:
  - If `abort` is high in LOAD, PULSE, DEAD or ACQ, the next state is IDLE and `aborted` pulses.
  - `tx_gate` and `frq_valid` drop on the next edge.
  - A sample captured on the abort cycle is dropped: no `acq_valid` follows.
  - `done` does not pulse.
  - `abort` in IDLE or DONE is ignored. DONE still completes and pulses `done`.
  - `start` and `abort` high together in IDLE: start wins. `abort` is evaluated from LOAD onward.
- `rst` mid-experiment: same effect as the reset values above, with no `done` and no `aborted` pulse.
- Counters are CW bits and never wrap: a maximum value of 2^CW-1 is honoured exactly.

## Timing
- `start` at edge t (sampled high): LOAD during cycle t+1, with `frq_valid` high for that cycle only.
- With pulse_len=P>0: `tx_gate` high during cycles t+2 .. t+1+P.
- The first cycle of DEAD is t+2+P; its last cycle is t+1+P+D.
- The first ACQ cycle follows immediately after DEAD.
- Sample latency is 1 cycle: `s_tvalid` at cycle k gives `acq_valid` at k+1.
- `done` is high in the cycle after the last `acq_valid`/`acq_last`.
- `busy` rises at t+1 and falls in the cycle after DONE.
- A new `start` is accepted in the first IDLE cycle after DONE.
- Minimum experiment length, with all lengths 0: LOAD, DONE, IDLE, so `done` is high at t+2.

## Test plan
- Nominal run: frq=5000000, phase=0, P=10, D=5, N=4, `s_tvalid` every 4 cycles with incrementing data.
  - `frq_valid` for 1 cycle at t+1 and `tx_gate` for exactly 10 cycles.
  - 4 `acq_valid` pulses with matching data; `acq_last` on the 4th; `done` the next cycle.
- Zero lengths:
  - P=0, D=0, N=0: `tx_gate` never high and `done` at t+2.
  - P=0, D=3, N=2: no pulse, and the first sample is accepted after 3 DEAD cycles.
- Dead-time discard: `s_tvalid` held high through PULSE and DEAD with N=3.
  - Exactly 3 `acq_valid`, all from ACQ-state inputs.
- Abort in PULSE at cycle 4 of P=10.
  - `tx_gate` low the next cycle, `aborted` pulses, no `done`, `busy` low, no `acq_valid`.
- Abort in ACQ after 2 of 5 samples, with `s_tvalid` high on the abort cycle.
  - Only 2 `acq_valid` outputs, no `acq_last`, `aborted` pulses.
- Start while busy, and `cfg` change mid-run.
  - Second `start` is ignored; the running experiment uses the latched values.
  - `rst` asserted in ACQ returns all outputs to 0 with no `done`.

Source files
------------

// File: rtl/nmr_acq_sequencer.sv
// nmr_acq_sequencer
// Single-shot NMR experiment sequencer: latches the host configuration on
// start, loads the DDS (frq/phase_offset + frq_valid), gates the excitation
// pulse (tx_gate), waits the receiver dead time and then captures
// cfg_n_samples decimated samples (acq_valid/acq_data/acq_last).
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start, abort                experiment control
//   cfg_frq, cfg_phase          DDS words, latched at start
//   cfg_pulse_len/dead_len/n_samples  stage lengths, latched at start
//   frq, phase_offset, frq_valid      to sin_source
//   tx_gate                     excitation pulse gate
//   s_tvalid, s_tdata           decimator stream in
//   acq_valid, acq_data, acq_last     captured sample stream out
//   busy, done, aborted         status
//
// done is decoded from the DONE state; aborted is registered and pulses in
// the first IDLE cycle after the abort was sampled.
module nmr_acq_sequencer #(
  parameter int CW = 24,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   cfg_frq,
  input  logic [31:0]   cfg_phase,
  input  logic [CW-1:0] cfg_pulse_len,
  input  logic [CW-1:0] cfg_dead_len,
  input  logic [CW-1:0] cfg_n_samples,
  output logic [31:0]   frq,
  output logic [31:0]   phase_offset,
  output logic          frq_valid,
  output logic          tx_gate,
  input  logic          s_tvalid,
  input  logic [DW-1:0] s_tdata,
  output logic          acq_valid,
  output logic [DW-1:0] acq_data,
  output logic          acq_last,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  typedef enum logic [2:0] {IDLE, LOAD, PULSE, DEAD, ACQ, DONE} st_t;

  st_t           state_q, state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sh_pulse, sh_dead, sh_n;
  logic          acq_take, take_last, active;
  st_t           after_load, after_pulse, after_dead;

  // Zero-length stages are skipped when choosing the next stage.
  assign after_dead  = (sh_n != '0) ? ACQ : DONE;
  assign after_pulse = (sh_dead != '0) ? DEAD : after_dead;
  assign after_load  = (sh_pulse != '0) ? PULSE : after_pulse;

  assign active    = (state_q == LOAD) || (state_q == PULSE) ||
                     (state_q == DEAD) || (state_q == ACQ);
  // Once the last sample is in flight (acq_last high) further input is
  // ignored; ACQ holds for that one cycle so done lands after acq_last.
  assign acq_take  = (state_q == ACQ) && s_tvalid && !abort && !acq_last;
  assign take_last = (cnt == sh_n - CW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = abort ? IDLE : after_load;
      PULSE: if (abort) state_d = IDLE;
             else if (cnt == sh_pulse - CW'(1)) state_d = after_pulse;
      DEAD:  if (abort) state_d = IDLE;
             else if (cnt == sh_dead - CW'(1)) state_d = after_dead;
      ACQ:   if (abort) state_d = IDLE;
             else if (acq_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign frq_valid = (state_q == LOAD);
  assign tx_gate   = (state_q == PULSE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt          <= '0;
      sh_pulse     <= '0;
      sh_dead      <= '0;
      sh_n         <= '0;
      frq          <= '0;
      phase_offset <= '0;
      acq_valid    <= 1'b0;
      acq_data     <= '0;
      acq_last     <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        frq          <= cfg_frq;
        phase_offset <= cfg_phase;
        sh_pulse     <= cfg_pulse_len;
        sh_dead      <= cfg_dead_len;
        sh_n         <= cfg_n_samples;
      end
      // cnt is the cycle count in PULSE/DEAD and the sample index in ACQ;
      // it never exceeds len-1, so a length of 2^CW-1 cannot wrap.
      if (state_d != state_q)
        cnt <= '0;
      else if (state_q == PULSE || state_q == DEAD)
        cnt <= cnt + CW'(1);
      else if (acq_take && !take_last)
        cnt <= cnt + CW'(1);
      acq_valid <= acq_take;
      acq_last  <= acq_take && take_last;
      if (acq_take) acq_data <= s_tdata;
      aborted <= active && abort;
    end
  end

endmodule
